// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - loads an N x N A/B matrix pair and feeds it diagonally skewed into a systolic array edge.
// Optional SKEW_FEEDER_DBUF_EN adds a shadow buffer so the next pair loads while the current one streams.
module skew_feeder #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N*W-1:0] i_a_row,
    input  logic [N*W-1:0] i_b_col,
    output logic [N*W-1:0] o_a,
    output logic [N*W-1:0] o_b,
    output logic           o_busy,
    output logic           o_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(N + 1);
    localparam int CW = $clog2(2 * N);

    localparam logic [IW-1:0] LAST_BEAT  = IW'(N - 1);
    localparam logic [CW-1:0] LAST_FEED  = CW'(2 * N - 2);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              beat_q, beat_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [N-1:0][N-1:0][W-1:0] a_q, a_d;
    logic [N-1:0][N-1:0][W-1:0] b_q, b_d;
    logic [N*W-1:0]             oa_q, oa_d;
    logic [N*W-1:0]             ob_q, ob_d;
    logic                       ready_q, ready_d;
    logic                       accept;

`ifdef SKEW_FEEDER_DBUF_EN
    localparam logic [SW-1:0] SH_FULL = SW'(N);

    logic [N-1:0][N-1:0][W-1:0] sa_q, sa_d;
    logic [N-1:0][N-1:0][W-1:0] sb_q, sb_d;
    logic [SW-1:0]              sh_q, sh_d;
`endif

    // A row buffer a[i][k] and B column buffer b[j][k] skew identically: lane i
    // carries element (t - i) during FEED cycle t.
    function automatic logic [N*W-1:0] skew_slice(
        input logic [N-1:0][N-1:0][W-1:0] mat,
        input logic [CW-1:0]              t
    );
        logic [N*W-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == i + k) begin
                    res[i*W +: W] = mat[i][k];
                end
            end
        end
        return res;
    endfunction

    assign accept  = i_valid & ready_q;
    assign o_ready = ready_q;
    assign o_a     = oa_q;
    assign o_b     = ob_q;
    assign o_busy  = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_DONE);
    assign o_done  = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        oa_d    = '0;
        ob_d    = '0;
        ready_d = 1'b0;
`ifdef SKEW_FEEDER_DBUF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        sh_d    = sh_q;

        if (accept && o_busy) begin
            sa_d[sh_q[IW-1:0]] = i_a_row;
            sb_d[sh_q[IW-1:0]] = i_b_col;
            sh_d               = sh_q + 1'b1;
        end
`endif

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    a_d[beat_q] = i_a_row;
                    b_d[beat_q] = i_b_col;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        cnt_d   = '0;
                        state_d = S_FEED;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_FEED: begin
                if (cnt_q == LAST_FEED) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifdef SKEW_FEEDER_DBUF_EN
                // Shadow contents (including a beat taken this cycle) become the active pair.
                if (sh_d != '0) begin
                    a_d  = sa_d;
                    b_d  = sb_d;
                    sh_d = '0;
                    if (sh_q + SW'(accept) == SH_FULL) begin
                        cnt_d   = '0;
                        state_d = S_FEED;
                    end else begin
                        beat_d  = IW'(sh_q + SW'(accept));
                        state_d = S_LOAD;
                    end
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Output registers are loaded with the value for the next cycle so the
        // first FEED cycle already presents t = 0.
        if (state_d == S_FEED) begin
            oa_d = skew_slice(a_d, cnt_d);
            ob_d = skew_slice(b_d, cnt_d);
        end

`ifdef SKEW_FEEDER_DBUF_EN
        ready_d = (sh_d != SH_FULL);
`else
        ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
`endif
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            ready_q <= ready_d;
        end
    end

`ifdef SKEW_FEEDER_DBUF_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            sa_q <= '0;
            sb_q <= '0;
            sh_q <= '0;
        end else begin
            sa_q <= sa_d;
            sb_q <= sb_d;
            sh_q <= sh_d;
        end
    end
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - directed table-driven bench for skew_feeder at N=4, W=8.
module tb_skew_feeder;

    localparam int NB = 4;
    localparam int WB = 8;
`ifdef SKEW_FEEDER_DBUF_EN
    localparam logic DBUF = 1'b1;
`else
    localparam logic DBUF = 1'b0;
`endif

    logic             i_clk;
    logic             i_arst_n;
    logic             i_valid;
    logic             o_ready;
    logic [NB*WB-1:0] i_a_row;
    logic [NB*WB-1:0] i_b_col;
    logic [NB*WB-1:0] o_a;
    logic [NB*WB-1:0] o_b;
    logic             o_busy;
    logic             o_done;

    skew_feeder #(.N(NB), .W(WB)) dut (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a_row  (i_a_row),
        .i_b_col  (i_b_col),
        .o_a      (o_a),
        .o_b      (o_b),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vt[2][13];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] row_a(input int r, input logic ff);
        logic [31:0] v;
        for (int k = 0; k < NB; k++) v[k*8 +: 8] = ff ? 8'hFF : 8'(16 * r + k);
        return v;
    endfunction

    function automatic logic [31:0] col_b(input int r, input logic ff);
        logic [31:0] v;
        for (int k = 0; k < NB; k++) v[k*8 +: 8] = ff ? 8'hFF : 8'(16 * k + r);
        return v;
    endfunction

    task automatic load_beat(input int r, input logic ff);
        @(negedge i_clk);
        chk($sformatf("ready before beat %0d", r), {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_a_row = row_a(r, ff);
        i_b_col = col_b(r, ff);
        @(posedge i_clk);
    endtask

    // Leaves i_valid high after the last beat; the caller drops it on the next negedge.
    task automatic load_mat(input logic ff, input int gap);
        for (int r = 0; r < NB; r++) begin
            load_beat(r, ff);
            if (r == 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge i_clk);
                    i_valid = 1'b0;
                    chk($sformatf("gap ready g=%0d", g), {31'b0, o_ready}, 32'd1);
                    chk($sformatf("gap busy g=%0d", g), {31'b0, o_busy}, 32'd0);
                end
            end
        end
    endtask

    task automatic run_table(input int s, input logic junk);
        logic exp_rdy;
        for (int c = 1; c <= 13; c++) begin
            @(negedge i_clk);
            exp_rdy = (c == 13) ? 1'b1 : DBUF;
            chk($sformatf("tbl%0d c%0d o_a", s, c), o_a, vt[s][c-1].a);
            chk($sformatf("tbl%0d c%0d o_b", s, c), o_b, vt[s][c-1].b);
            chk($sformatf("tbl%0d c%0d busy", s, c), {31'b0, o_busy}, {31'b0, vt[s][c-1].busy});
            chk($sformatf("tbl%0d c%0d done", s, c), {31'b0, o_done}, {31'b0, vt[s][c-1].done});
            chk($sformatf("tbl%0d c%0d ready", s, c), {31'b0, o_ready}, {31'b0, exp_rdy});
            i_valid = junk && (c < 12);
            i_a_row = 32'hFFFF_FFFF;
            i_b_col = 32'hFFFF_FFFF;
        end
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        int pulses;
        lat    = -1;
        pulses = 0;
        for (int c = 1; c <= 3 * NB + 4; c++) begin
            @(negedge i_clk);
            if (c == 1) i_valid = 1'b0;
            if (c == 4) chk("gap load t=3 o_a", o_a, 32'h3021_1203);
            if (o_done) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        chk("done latency", lat, exp_lat);
        chk("done pulse count", pulses, 1);
    endtask

    initial begin
        vt[0][0] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vt[0][1] = '{32'h0000_1001, 32'h0000_0110, 1'b1, 1'b0};
        vt[0][2] = '{32'h0020_1102, 32'h0002_1120, 1'b1, 1'b0};
        vt[0][3] = '{32'h3021_1203, 32'h0312_2130, 1'b1, 1'b0};
        vt[0][4] = '{32'h3122_1300, 32'h1322_3100, 1'b1, 1'b0};
        vt[0][5] = '{32'h3223_0000, 32'h2332_0000, 1'b1, 1'b0};
        vt[0][6] = '{32'h3300_0000, 32'h3300_0000, 1'b1, 1'b0};
        vt[1][0] = '{32'h0000_00FF, 32'h0000_00FF, 1'b1, 1'b0};
        vt[1][1] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0};
        vt[1][2] = '{32'h00FF_FFFF, 32'h00FF_FFFF, 1'b1, 1'b0};
        vt[1][3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[1][4] = '{32'hFFFF_FF00, 32'hFFFF_FF00, 1'b1, 1'b0};
        vt[1][5] = '{32'hFFFF_0000, 32'hFFFF_0000, 1'b1, 1'b0};
        vt[1][6] = '{32'hFF00_0000, 32'hFF00_0000, 1'b1, 1'b0};
        for (int s = 0; s < 2; s++) begin
            for (int c = 7; c < 11; c++) vt[s][c] = '{32'h0, 32'h0, 1'b1, 1'b0};
            vt[s][11] = '{32'h0, 32'h0, 1'b1, 1'b1};
            vt[s][12] = '{32'h0, 32'h0, 1'b0, 1'b0};
        end

        i_arst_n = 1'b0;
        i_valid  = 1'b0;
        i_a_row  = '0;
        i_b_col  = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset o_ready", {31'b0, o_ready}, 32'd0);
        chk("reset o_busy", {31'b0, o_busy}, 32'd0);
        chk("reset o_done", {31'b0, o_done}, 32'd0);
        chk("reset o_a", o_a, 32'h0);
        chk("reset o_b", o_b, 32'h0);
        i_arst_n = 1'b1;
        @(negedge i_clk);
        chk("ready after release", {31'b0, o_ready}, 32'd1);

        load_mat(1'b0, 0);
        run_table(0, !DBUF);

        load_mat(1'b1, 0);
        run_table(1, 1'b0);

        load_mat(1'b0, 5);
        wait_done(12);

        load_mat(1'b0, 0);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("pre-reset t=2 o_a", o_a, 32'h0020_1102);
        i_arst_n = 1'b0;
        #1;
        chk("mid-feed reset o_a", o_a, 32'h0);
        chk("mid-feed reset o_b", o_b, 32'h0);
        chk("mid-feed reset busy", {31'b0, o_busy}, 32'd0);
        chk("mid-feed reset ready", {31'b0, o_ready}, 32'd0);
        chk("mid-feed reset done", {31'b0, o_done}, 32'd0);
        @(negedge i_clk);
        chk("held reset ready", {31'b0, o_ready}, 32'd0);
        i_arst_n = 1'b1;
        @(negedge i_clk);
        chk("post-reset ready", {31'b0, o_ready}, 32'd1);
        chk("post-reset busy", {31'b0, o_busy}, 32'd0);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge i_clk);
                if (o_done) pulses++;
            end
            chk("no done after reset", pulses, 0);
        end

`ifdef SKEW_FEEDER_DBUF_EN
        begin
            int done1;
            int done2;
            int idle_gap;
            done1    = -1;
            done2    = -1;
            idle_gap = 0;
            load_mat(1'b0, 0);
            for (int c = 1; c <= 26; c++) begin
                @(negedge i_clk);
                if (o_done) begin
                    if (done1 < 0) done1 = c;
                    else if (done2 < 0) done2 = c;
                end
                if (c <= 24 && !o_busy) idle_gap++;
                if (c == 4) chk("dbuf t=3 o_a", o_a, 32'h3021_1203);
                if (c == 13) chk("dbuf swap t=0 o_a", o_a, 32'h0000_00FF);
                if (c == 13) chk("dbuf swap t=0 o_b", o_b, 32'h0000_00FF);
                if (c == 16) chk("dbuf swap t=3 o_a", o_a, 32'hFFFF_FFFF);
                if (c == 25) chk("dbuf end busy", {31'b0, o_busy}, 32'd0);
                if (c == 25) chk("dbuf end ready", {31'b0, o_ready}, 32'd1);
                if (c <= 4) begin
                    chk($sformatf("shadow ready c%0d", c), {31'b0, o_ready}, 32'd1);
                    i_valid = 1'b1;
                    i_a_row = row_a(c - 1, 1'b1);
                    i_b_col = col_b(c - 1, 1'b1);
                end else begin
                    i_valid = 1'b0;
                    if (c == 5) chk("shadow full ready", {31'b0, o_ready}, 32'd0);
                end
            end
            chk("dbuf first done", done1, 12);
            chk("dbuf second done", done2, 24);
            chk("dbuf idle gap", idle_gap, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
